// File: rtl/l4_pkg.sv
// Shared constants, word types and FSM encoding for the layer-4 accumulator.
package l4_pkg;

    localparam int unsigned N_OUT = 16;
    localparam int unsigned ACC_W = 36;
    localparam int unsigned OUT_W = 18;
    localparam int unsigned IDX_W = $clog2(N_OUT);

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/l4_sat_shift.sv
// Combinational arithmetic right shift, clamp to OUT_W bits and optional ReLU.
// Build option: define L4_ACCUM_RELU_EN to force negative results to zero.
module l4_sat_shift
    import l4_pkg::*;
#(
    parameter int unsigned SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] res_c_o
);

    localparam acc_t SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam acc_t SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    acc_t shifted;

    assign shifted = acc_t'($signed(acc_i) >>> SHIFT);

    always_comb begin
        res_c_o = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            res_c_o = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            res_c_o = {1'b1, {(OUT_W-1){1'b0}}};
        end
`ifdef L4_ACCUM_RELU_EN
        if (res_c_o[OUT_W-1]) begin
            res_c_o = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/l4_accum.sv
// Per-neuron accumulation of N_IN product beats, then a rescaled/saturated drain
// of the N_OUT sums, one per handshake. Build option: L4_ACCUM_RELU_EN (see l4_sat_shift).
module l4_accum
    import l4_pkg::*;
#(
    parameter int unsigned N_IN  = 32,
    parameter int unsigned SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     prod_valid,
    input  logic [N_OUT*ACC_W-1:0]   prod,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [OUT_W-1:0]         dout,
    output logic [IDX_W-1:0]         dout_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q [N_OUT];
    logic [ACC_W-1:0]       acc_d [N_OUT];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [OUT_W-1:0]       dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   last_beat;
    logic                   last_idx;
    logic                   handshake;
    logic [ACC_W-1:0]       acc_sel;

    assign last_beat = (cnt_q == CNT_W'(N_IN - 1));
    assign last_idx  = (idx_q == IDX_W'(N_OUT - 1));
    assign handshake = dout_valid_q & dout_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (prod_valid && last_beat) state_d = DRAIN;
            DRAIN:   if (handshake && last_idx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
                    cnt_d = '0;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_d[j] = acc_q[j] + prod[j*ACC_W +: ACC_W];
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        idx_d        = '0;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (last_idx) begin
                        dout_valid_d = 1'b0;
                        done_d       = 1'b1;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
        acc_sel = acc_d[idx_d];
    end

    // Output word is computed from next-cycle sums so it lands with dout_valid
    l4_sat_shift #(
        .SHIFT   (SHIFT)
    ) u_sat (
        .acc_i   (acc_sel),
        .res_c_o (dout_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_l4_accum.sv
// Scoreboard bench for l4_accum: two instances (SHIFT=0 and SHIFT=8, N_IN=4) share stimulus.
module tb_l4_accum;
    import l4_pkg::*;

    localparam int unsigned NB = 4;

    typedef struct packed {
        logic [3:0]  idx;
        logic [17:0] val;
    } exp_t;

    typedef struct {
        string  name;
        int     sel;
        longint exp;
    } dchk_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   prod_valid;
    logic [N_OUT*ACC_W-1:0] prod;
    logic                   dout_ready;
    logic                   dv0, dv8, busy0, busy8, done0, done8;
    logic [OUT_W-1:0]       dout0, dout8;
    logic [IDX_W-1:0]       idx0, idx8;

    exp_t   exp0[$];
    exp_t   exp8[$];
    dchk_t  dq[$];
    longint vec  [N_OUT];
    longint sums [N_OUT];
    int     n_vec = 0;
    int     n_mis = 0;
    bit     chk_done0 = 0;
    bit     chk_done8 = 0;

    always #5 clk = ~clk;

    l4_accum #(.N_IN(NB), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .prod_valid(prod_valid), .prod(prod),
        .dout_valid(dv0), .dout_ready(dout_ready), .dout(dout0), .dout_idx(idx0),
        .busy(busy0), .done(done0)
    );

    l4_accum #(.N_IN(NB), .SHIFT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .prod_valid(prod_valid), .prod(prod),
        .dout_valid(dv8), .dout_ready(dout_ready), .dout(dout8), .dout_idx(idx8),
        .busy(busy8), .done(done8)
    );

    // Reference: floor shift, clamp to 18-bit signed, optional ReLU
    function automatic logic [17:0] model(input longint s, input int sh);
        longint r;
        r = s >>> sh;
        if (r > 131071) r = 131071;
        else if (r < -131072) r = -131072;
`ifdef L4_ACCUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return 18'(r);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshakes, done-pulse tracking, directed snapshots
    always @(negedge clk) begin
        exp_t  e;
        dchk_t d;
        longint act;
        if (chk_done0) begin
            chk("done0_pulse", longint'(done0), 1);
            chk("busy0_after_done", longint'(busy0), 0);
            chk("dv0_after_done", longint'(dv0), 0);
            chk_done0 = 0;
        end else if (done0) begin
            chk("done0_spurious", longint'(done0), 0);
        end
        if (chk_done8) begin
            chk("done8_pulse", longint'(done8), 1);
            chk("busy8_after_done", longint'(busy8), 0);
            chk_done8 = 0;
        end else if (done8) begin
            chk("done8_spurious", longint'(done8), 0);
        end
        if (dv0 && dout_ready) begin
            if (exp0.size() == 0) begin
                chk("out0_pending", longint'(exp0.size()), 1);
            end else begin
                e = exp0.pop_front();
                chk($sformatf("dout0[%0d]", e.idx), longint'($signed(dout0)), longint'($signed(e.val)));
                chk("idx0", longint'(idx0), longint'(e.idx));
                if (e.idx == 4'd15) chk_done0 = 1;
            end
        end
        if (dv8 && dout_ready) begin
            if (exp8.size() == 0) begin
                chk("out8_pending", longint'(exp8.size()), 1);
            end else begin
                e = exp8.pop_front();
                chk($sformatf("dout8[%0d]", e.idx), longint'($signed(dout8)), longint'($signed(e.val)));
                chk("idx8", longint'(idx8), longint'(e.idx));
                if (e.idx == 4'd15) chk_done8 = 1;
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            case (d.sel)
                0:       act = longint'(dv0);
                1:       act = longint'(busy0);
                2:       act = longint'(done0);
                3:       act = longint'($signed(dout0));
                4:       act = longint'(idx0);
                5:       act = longint'(dv8);
                default: act = longint'(exp0.size() + exp8.size());
            endcase
            chk(d.name, act, d.exp);
        end
    end

    task automatic dput(input string nm, input int sel, input longint exp);
        dchk_t d;
        d.name = nm; d.sel = sel; d.exp = exp;
        dq.push_back(d);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_sums();
        for (int j = 0; j < N_OUT; j++) sums[j] = 0;
    endtask

    task automatic set_vec(input longint base, input longint step);
        for (int j = 0; j < N_OUT; j++) vec[j] = base + step * j;
    endtask

    task automatic push_expect();
        exp_t e;
        for (int j = 0; j < N_OUT; j++) begin
            e.idx = 4'(j);
            e.val = model(sums[j], 0);
            exp0.push_back(e);
            e.val = model(sums[j], 8);
            exp8.push_back(e);
        end
    endtask

    task automatic load_prod();
        for (int j = 0; j < N_OUT; j++) prod[j*ACC_W +: ACC_W] = ACC_W'(vec[j]);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        clear_sums();
    endtask

    task automatic beat(input bit last);
        load_prod();
        prod_valid = 1'b1;
        for (int j = 0; j < N_OUT; j++) sums[j] += vec[j];
        if (last) push_expect();
        cyc(1);
        prod_valid = 1'b0;
        if (last) begin
            dput("latency_dv0", 0, 1);
            dput("latency_dv8", 5, 1);
        end
    endtask

    task automatic run_beats();
        for (int b = 0; b < int'(NB); b++) beat(b == int'(NB) - 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (exp0.size() == 0 && exp8.size() == 0 && !busy0 && !busy8) break;
        end
        dput("drain_complete", 6, 0);
        cyc(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod       = '0;
        dout_ready = 1'b1;
        clear_sums();
        cyc(3);
        dput("rst_dv0", 0, 0);
        dput("rst_busy0", 1, 0);
        dput("rst_done0", 2, 0);
        dput("rst_dout0", 3, 0);
        dput("rst_idx0", 4, 0);
        dput("rst_dv8", 5, 0);
        rst_n = 1'b1;
        cyc(2);

        // Basic: prod[j]=j+1 x4 -> 4,8,...,64 (SHIFT=8 instance: all 0)
        do_start();
        dput("busy0_accum", 1, 1);
        set_vec(1, 1);
        run_beats();
        wait_drain();

        // Saturation: -400000 -> -131072 (0 with ReLU), +400000 -> 131071
        do_start();
        set_vec(0, 0);
        vec[0] = -100000;
        vec[1] = 100000;
        run_beats();
        wait_drain();

        // Back-pressure at idx 3: word 16 held for 5 cycles
        do_start();
        set_vec(1, 1);
        run_beats();
        for (int i = 0; i < 40; i++) begin
            if (idx0 == 4'd3) break;
            cyc(1);
        end
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            dput("stall_idx0", 4, 3);
            dput("stall_dout0", 3, 16);
            dput("stall_dv0", 0, 1);
        end
        dout_ready = 1'b1;
        wait_drain();

        // IDLE pulses ignored; gapped beats and a mid-ACCUM start give gapless sums
        set_vec(5, 0);
        load_prod();
        repeat (2) begin
            prod_valid = 1'b1;
            cyc(1);
            prod_valid = 1'b0;
            cyc(1);
        end
        dput("idle_pulse_busy0", 1, 0);
        do_start();
        set_vec(1, 1);
        beat(0);
        cyc(3);
        beat(0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        beat(0);
        cyc(3);
        dput("gap_dv0", 0, 0);
        dput("gap_busy0", 1, 1);
        beat(1);
        wait_drain();

        // Mid-inference reset discards partial sums
        do_start();
        set_vec(7, 0);
        beat(0);
        beat(0);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        clear_sums();
        dput("abort_busy0", 1, 0);
        dput("abort_dv0", 0, 0);
        dput("abort_idx0", 4, 0);
        cyc(1);
        do_start();
        set_vec(1, 0);
        run_beats();
        wait_drain();

        // Floor shift: 1000 -> 3, -1000 -> -4 on the SHIFT=8 instance
        do_start();
        set_vec(0, 0);
        vec[0] = 250;
        vec[1] = -250;
        run_beats();
        wait_drain();

        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
